mw_sync_fifo: RTL

MW_SYNC_FIFO -- requirements
Module: mw_sync_fifo

---
 rtl/mw_sync_fifo_pkg.sv | 32 +++
 rtl/mw_sync_fifo_lane_prefix_count.sv | 29 ++
 rtl/mw_sync_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/mw_sync_fifo_pkg.sv
// Shared helpers for the multi-lane synchronous FIFO: status flag bundle and
// width/flag derivation functions used by the top and its lane counter.
package mw_sync_fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic afull;
        logic ready;
    } fifo_status_t;

    // Bits needed to hold a lane count in the range 0..lanes.
    function automatic int unsigned lane_cnt_width(input int unsigned lanes);
        return (lanes < 2) ? 1 : $clog2(lanes + 1);
    endfunction

    // Flags are pure functions of occupancy; ready means a full set of lanes fits.
    function automatic fifo_status_t status_of(
        input int unsigned cnt,
        input int unsigned depth,
        input int unsigned thresh,
        input int unsigned lanes
    );
        fifo_status_t s;
        s.empty = (cnt == 0);
        s.full  = (cnt == depth);
        s.afull = (cnt >= thresh);
        s.ready = ((depth - cnt) >= lanes);
        return s;
    endfunction

endpackage

// File: rtl/mw_sync_fifo_lane_prefix_count.sv
// lane_prefix_count: length of the contiguous run of ones starting at bit 0
// of a lane mask (lanes past the first clear bit never count).
module lane_prefix_count
    import mw_sync_fifo_pkg::*;
#(
    parameter int LANES = 2,
    localparam int RW = lane_cnt_width(LANES)
) (
    input  logic [LANES-1:0] mask,
    output logic [RW-1:0]    run
);

    logic [LANES-1:0] therm;

    // therm[i] is set only if every lane up to and including i is set.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_therm
            assign therm[gi] = &mask[gi:0];
        end
    endgenerate

    always_comb begin
        run = '0;
        for (int i = 0; i < LANES; i++) begin
            run = run + RW'(therm[i]);
        end
    end

endmodule

// File: rtl/mw_sync_fifo.sv
// Multi-lane synchronous FIFO: up to LANES pushes and LANES pops per cycle,
// first-word-fall-through read ports, wrap-bit pointers for occupancy.
module mw_sync_fifo
    import mw_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int QUEUE_DEPTH  = 16,
    parameter int LANES        = 2,
    parameter int AFULL_THRESH = QUEUE_DEPTH - LANES,
    localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [LANES-1:0]            enqueue,
    input  logic [LANES*DATA_WIDTH-1:0] wdata,
    output logic                        enq_ready,
    input  logic [LANES-1:0]            dequeue,
    output logic [LANES*DATA_WIDTH-1:0] rdata,
    output logic [LANES-1:0]            rvalid,
    output logic [CNT_WIDTH-1:0]        count,
    output logic                        is_full,
    output logic                        is_empty,
    output logic                        almost_full
);

    localparam int AW  = $clog2(QUEUE_DEPTH);
    localparam int LCW = lane_cnt_width(LANES);

    logic [CNT_WIDTH-1:0]  wptr_reg;
    logic [CNT_WIDTH-1:0]  wptr_next;
    logic [CNT_WIDTH-1:0]  rptr_reg;
    logic [CNT_WIDTH-1:0]  rptr_next;
    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [LANES-1:0]      enq_mask;
    logic [LANES-1:0]      deq_mask;
    logic [LCW-1:0]        enq_cnt;
    logic [LCW-1:0]        deq_cnt;
    logic [AW-1:0]         wr_idx [LANES];
    logic [AW-1:0]         rd_idx [LANES];
    fifo_status_t          status;

    // The wrap bit makes the modular difference the true occupancy, full included.
    assign count  = wptr_reg - rptr_reg;
    assign status = status_of(32'(count), QUEUE_DEPTH, AFULL_THRESH, LANES);

    assign enq_ready   = status.ready;
    assign is_empty    = status.empty;
    assign is_full     = status.full;
    assign almost_full = status.afull;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_idx[gi]   = wptr_reg[AW-1:0] + AW'(gi);
            assign rd_idx[gi]   = rptr_reg[AW-1:0] + AW'(gi);
            assign rvalid[gi]   = (count > CNT_WIDTH'(gi));
            assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx[gi]];
            // Readiness comes from registered occupancy only, so a same-cycle
            // pop can never make room for a push.
            assign enq_mask[gi] = enqueue[gi] & enq_ready & ~flush;
            assign deq_mask[gi] = dequeue[gi] & rvalid[gi];
        end
    endgenerate

    lane_prefix_count #(.LANES(LANES)) u_enq_count (
        .mask (enq_mask),
        .run  (enq_cnt)
    );

    lane_prefix_count #(.LANES(LANES)) u_deq_count (
        .mask (deq_mask),
        .run  (deq_cnt)
    );

    always_comb begin
        wptr_next = wptr_reg + CNT_WIDTH'(enq_cnt);
        rptr_next = rptr_reg + CNT_WIDTH'(deq_cnt);
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!rst && (i < int'(enq_cnt))) begin
                mem[wr_idx[i]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
